// File: rtl/tawas_pkg.sv
// Shared Tawas definitions: AU op/slice widths, writeback latency and the
// host-injection FSM state encoding.
package tawas_pkg;

  localparam int AU_OP_W      = 15;
  localparam int SLICE_W      = 2;
  localparam int AU_DATA_W    = 32;
  localparam int AU_WB_LAT    = 2;
  localparam int WAIT_CNT_W   = 8;
  localparam int FLIGHT_CNT_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_FLIGHT = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/tawas_au_arb.sv
// Injects host ops into free AU slots of a chosen thread slice, tracks them
// through AU writeback and returns the result; core ops pass with no latency.
module tawas_au_arb
  import tawas_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SLICE_W-1:0]   slice,
  input  logic                 core_op_vld,
  input  logic [AU_OP_W-1:0]   core_op,
  input  logic                 host_req,
  input  logic [SLICE_W-1:0]   host_slice,
  input  logic [AU_OP_W-1:0]   host_op,
  output logic                 host_ack,
  output logic                 host_busy,
  output logic                 host_rsp_vld,
  output logic [AU_DATA_W-1:0] host_rsp_data,
  output logic                 host_rsp_wb,
  output logic                 host_rsp_err,
  output logic                 au_op_vld,
  output logic [AU_OP_W-1:0]   au_op,
  input  logic                 au_rc_vld,
  input  logic [AU_DATA_W-1:0] au_rc
);

  localparam logic [WAIT_CNT_W-1:0]   TIMEOUT_CNT = WAIT_CNT_W'(TIMEOUT);
  localparam logic [FLIGHT_CNT_W-1:0] FLIGHT_LOAD = FLIGHT_CNT_W'(AU_WB_LAT - 1);

  arb_state_e              state;
  arb_state_e              state_nxt;
  logic [SLICE_W-1:0]      req_slice;
  logic [AU_OP_W-1:0]      req_op;
  logic [WAIT_CNT_W-1:0]   wait_cnt;
  logic [FLIGHT_CNT_W-1:0] flight_cnt;
  logic                    grant;
  logic                    timeout;
  logic                    capture;

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    grant     = (state == ST_WAIT) && (slice == req_slice) && !core_op_vld;
    timeout   = (state == ST_WAIT) && !grant && (wait_cnt == TIMEOUT_CNT);
    capture   = (state == ST_FLIGHT) && (flight_cnt == '0);
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (host_req) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (grant)        state_nxt = ST_FLIGHT;
        else if (timeout) state_nxt = ST_RESP;
      end
      ST_FLIGHT: if (capture) state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // The core path is purely combinational; the host op only borrows a slot
  // the decoder left empty on the latched slice.
  always_comb begin
    au_op_vld    = core_op_vld | grant;
    au_op        = grant ? req_op : core_op;
    host_ack     = grant | timeout;
    host_busy    = (state != ST_IDLE);
    host_rsp_vld = (state == ST_RESP);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      req_slice     <= '0;
      req_op        <= '0;
      wait_cnt      <= '0;
      flight_cnt    <= '0;
      host_rsp_data <= '0;
      host_rsp_wb   <= 1'b0;
      host_rsp_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        ST_IDLE: begin
          if (host_req) begin
            req_slice <= host_slice;
            req_op    <= host_op;
            wait_cnt  <= '0;
          end
        end
        ST_WAIT: begin
          if (grant) begin
            flight_cnt <= FLIGHT_LOAD;
          end else if (timeout) begin
            host_rsp_data <= '0;
            host_rsp_wb   <= 1'b0;
            host_rsp_err  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_FLIGHT: begin
          // Writeback in this cycle can only belong to the injected op.
          if (capture) begin
            host_rsp_wb   <= au_rc_vld;
            host_rsp_data <= au_rc_vld ? au_rc : '0;
            host_rsp_err  <= 1'b0;
          end else begin
            flight_cnt <= flight_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tawas_au_arb.sv
// Directed bench for tawas_au_arb with a 2-cycle AU stub and TIMEOUT=8.
module tb_tawas_au_arb;

  localparam logic [3:0] CMD_ADDI = 4'h1;
  localparam logic [3:0] CMD_CORE = 4'h2;
  localparam logic [3:0] CMD_CMP  = 4'hB;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  slice;
  logic        core_op_vld;
  logic [14:0] core_op;
  logic        host_req;
  logic [1:0]  host_slice;
  logic [14:0] host_op;
  logic        host_ack;
  logic        host_busy;
  logic        host_rsp_vld;
  logic [31:0] host_rsp_data;
  logic        host_rsp_wb;
  logic        host_rsp_err;
  logic        au_op_vld;
  logic [14:0] au_op;
  logic        au_rc_vld;
  logic [31:0] au_rc;

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;
  logic [3:0] core_mask = 4'b0000;

  always #5 clk = ~clk;

  tawas_au_arb #(.TIMEOUT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .slice        (slice),
    .core_op_vld  (core_op_vld),
    .core_op      (core_op),
    .host_req     (host_req),
    .host_slice   (host_slice),
    .host_op      (host_op),
    .host_ack     (host_ack),
    .host_busy    (host_busy),
    .host_rsp_vld (host_rsp_vld),
    .host_rsp_data(host_rsp_data),
    .host_rsp_wb  (host_rsp_wb),
    .host_rsp_err (host_rsp_err),
    .au_op_vld    (au_op_vld),
    .au_op        (au_op),
    .au_rc_vld    (au_rc_vld),
    .au_rc        (au_rc)
  );

  // AU stub: op = {cmd, rd, imm}; ADD-style cmds write rf[rd]+imm two cycles
  // after issue, compare writes nothing. Not reset: issued ops always finish.
  function automatic logic [31:0] rf_val(input logic [2:0] rd);
    case (rd)
      3'd1:    rf_val = 32'd5;
      3'd2:    rf_val = 32'h20;
      default: rf_val = {21'd0, rd, 8'd0};
    endcase
  endfunction

  function automatic logic [14:0] mk_op(input logic [3:0] cmd, input logic [2:0] rd,
                                        input logic [7:0] imm);
    mk_op = {cmd, rd, imm};
  endfunction

  logic        s1_vld = 1'b0, s2_vld = 1'b0;
  logic [14:0] s1_op = '0, s2_op = '0;
  always_ff @(posedge clk) begin
    s1_vld <= au_op_vld;
    s1_op  <= au_op;
    s2_vld <= s1_vld;
    s2_op  <= s1_op;
  end
  assign au_rc_vld = s2_vld && (s2_op[14:11] != CMD_CMP);
  assign au_rc     = au_rc_vld ? rf_val(s2_op[10:8]) + {24'd0, s2_op[7:0]} : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle: inputs change 1 time unit after the edge, outputs are
  // sampled 3 units after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    slice       = slice + 2'd1;
    cyc_n++;
    core_op_vld = core_mask[slice];
    core_op     = mk_op(CMD_CORE, 3'd3, 8'(cyc_n));
    #2;
  endtask

  task automatic wait_slice(input logic [1:0] s);
    while (slice != s) cyc();
  endtask

  task automatic request(input logic [1:0] s, input logic [14:0] op);
    host_req   = 1'b1;
    host_slice = s;
    host_op    = op;
  endtask

  task automatic check_rsp(input string tag, input logic [31:0] data, input logic wb,
                           input logic err);
    check({tag, "_rsp_vld"},  32'(host_rsp_vld), 32'd1);
    check({tag, "_rsp_data"}, host_rsp_data, data);
    check({tag, "_rsp_wb"},   32'(host_rsp_wb), 32'(wb));
    check({tag, "_rsp_err"},  32'(host_rsp_err), 32'(err));
  endtask

  initial begin
    rst         = 1'b1;
    slice       = 2'd3;
    core_op_vld = 1'b0;
    core_op     = '0;
    host_req    = 1'b0;
    host_slice  = '0;
    host_op     = '0;

    // Reset state.
    cyc();
    cyc();
    check("rst_ack",      32'(host_ack), 32'd0);
    check("rst_busy",     32'(host_busy), 32'd0);
    check("rst_rsp_vld",  32'(host_rsp_vld), 32'd0);
    check("rst_rsp_data", host_rsp_data, 32'd0);
    check("rst_rsp_wb",   32'(host_rsp_wb), 32'd0);
    check("rst_rsp_err",  32'(host_rsp_err), 32'd0);
    check("rst_au_vld",   32'(au_op_vld), 32'd0);
    check("rst_au_op",    32'(au_op), 32'(core_op));
    rst = 1'b0;

    // 1: ADD-imm r1(5)+3 on slice 2, requested while slice=0.
    wait_slice(2'd0);
    request(2'd2, mk_op(CMD_ADDI, 3'd1, 8'd3));
    check("t1_idle_busy", 32'(host_busy), 32'd0);
    cyc();
    check("t1_wait_busy", 32'(host_busy), 32'd1);
    check("t1_wait_ack",  32'(host_ack), 32'd0);
    check("t1_wait_vld",  32'(au_op_vld), 32'd0);
    cyc();
    check("t1_grant_vld", 32'(au_op_vld), 32'd1);
    check("t1_grant_op",  32'(au_op), 32'(mk_op(CMD_ADDI, 3'd1, 8'd3)));
    check("t1_grant_ack", 32'(host_ack), 32'd1);
    host_req = 1'b0;
    cyc();
    check("t1_t1_ack", 32'(host_ack), 32'd0);
    check("t1_t1_vld", 32'(host_rsp_vld), 32'd0);
    cyc();
    check("t1_t2_vld", 32'(host_rsp_vld), 32'd0);
    cyc();
    check_rsp("t1", 32'd8, 1'b1, 1'b0);
    cyc();
    check("t1_after_vld",  32'(host_rsp_vld), 32'd0);
    check("t1_after_busy", 32'(host_busy), 32'd0);
    check("t1_hold_data",  host_rsp_data, 32'd8);

    // 2: compare op on slice 0, no writeback.
    wait_slice(2'd3);
    request(2'd0, mk_op(CMD_CMP, 3'd1, 8'd7));
    cyc();
    check("t2_grant_ack", 32'(host_ack), 32'd1);
    check("t2_grant_vld", 32'(au_op_vld), 32'd1);
    host_req = 1'b0;
    cyc();
    cyc();
    cyc();
    check_rsp("t2", 32'd0, 1'b0, 1'b0);
    cyc();
    check("t2_after_vld", 32'(host_rsp_vld), 32'd0);

    // 3: slice 1 always taken by the core -> timeout at r+9.
    core_mask = 4'b0010;
    wait_slice(2'd0);
    request(2'd1, mk_op(CMD_ADDI, 3'd1, 8'd1));
    for (int i = 1; i <= 9; i++) begin
      cyc();
      check($sformatf("t3_ack_%0d", i), 32'(host_ack), (i == 9) ? 32'd1 : 32'd0);
      check($sformatf("t3_vld_%0d", i), 32'(au_op_vld), 32'(core_op_vld));
      if (core_op_vld) check($sformatf("t3_op_%0d", i), 32'(au_op), 32'(core_op));
    end
    host_req  = 1'b0;
    core_mask = 4'b0000;
    cyc();
    check_rsp("t3", 32'd0, 1'b0, 1'b1);
    cyc();
    check("t3_after_busy", 32'(host_busy), 32'd0);

    // 4: core op takes the first slice-3 slot, host gets the next one.
    wait_slice(2'd2);
    request(2'd3, mk_op(CMD_ADDI, 3'd1, 8'h0A));
    core_mask = 4'b1000;
    cyc();
    check("t4_core_vld", 32'(au_op_vld), 32'd1);
    check("t4_core_op",  32'(au_op), 32'(core_op));
    check("t4_core_ack", 32'(host_ack), 32'd0);
    core_mask = 4'b0000;
    for (int i = 2; i <= 4; i++) begin
      cyc();
      check($sformatf("t4_ack_%0d", i), 32'(host_ack), 32'd0);
    end
    cyc();
    check("t4_grant_ack", 32'(host_ack), 32'd1);
    check("t4_grant_op",  32'(au_op), 32'(mk_op(CMD_ADDI, 3'd1, 8'h0A)));
    host_req = 1'b0;
    cyc();
    cyc();
    cyc();
    check_rsp("t4", 32'd15, 1'b1, 1'b0);

    // 5: first free slice-1 slot arrives exactly when wait count hits 8.
    core_mask = 4'b0010;
    wait_slice(2'd0);
    request(2'd1, mk_op(CMD_ADDI, 3'd2, 8'h10));
    for (int i = 1; i <= 8; i++) begin
      cyc();
      check($sformatf("t5_ack_%0d", i), 32'(host_ack), 32'd0);
      if (i == 5) core_mask = 4'b0000;
    end
    cyc();
    check("t5_grant_ack", 32'(host_ack), 32'd1);
    check("t5_grant_vld", 32'(au_op_vld), 32'd1);
    check("t5_grant_op",  32'(au_op), 32'(mk_op(CMD_ADDI, 3'd2, 8'h10)));
    host_req = 1'b0;
    cyc();
    cyc();
    cyc();
    check_rsp("t5", 32'h30, 1'b1, 1'b0);

    // 6: reset during FLIGHT, then a fresh request.
    wait_slice(2'd1);
    request(2'd2, mk_op(CMD_ADDI, 3'd1, 8'd1));
    cyc();
    check("t6_grant_ack", 32'(host_ack), 32'd1);
    host_req = 1'b0;
    cyc();
    check("t6_flight_busy", 32'(host_busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_busy",     32'(host_busy), 32'd0);
    check("t6_rst_ack",      32'(host_ack), 32'd0);
    check("t6_rst_rsp_vld",  32'(host_rsp_vld), 32'd0);
    check("t6_rst_rsp_data", host_rsp_data, 32'd0);
    check("t6_rst_rsp_wb",   32'(host_rsp_wb), 32'd0);
    check("t6_rst_rsp_err",  32'(host_rsp_err), 32'd0);
    check("t6_rst_au_vld",   32'(au_op_vld), 32'd0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check($sformatf("t6_no_rsp_%0d", i), 32'(host_rsp_vld), 32'd0);
      check($sformatf("t6_idle_%0d", i),   32'(host_busy), 32'd0);
    end
    wait_slice(2'd3);
    request(2'd0, mk_op(CMD_ADDI, 3'd2, 8'd1));
    cyc();
    check("t6b_grant_ack", 32'(host_ack), 32'd1);
    host_req = 1'b0;
    cyc();
    cyc();
    cyc();
    check_rsp("t6b", 32'h21, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tawas_au_arb.md
# tawas_au_arb

Shares the Tawas arithmetic unit's op slot between the core instruction decoder and a host/debug requester. Core ops always pass through unchanged. A host op is injected only in a cycle where the target slice owns the AU slot and the decoder presents no op. The block tracks the injected op through the AU's 2-cycle writeback latency and returns the AU result to the host. It sits between decode and the `au_op_vld`/`au_op` inputs of the AU, and observes the AU writeback port.

## Interface
- `TIMEOUT`, 64: wait cycles without a free slot before a host request is abandoned with an error; range 1..255.
- `clk`  in  1  core clock
- `rst`  in  1  asynchronous, active-high reset
- `slice`  in  2  current thread slice, rotates 0→1→2→3→0 every cycle
- `core_op_vld`  in  1  decoder has an AU op this cycle
- `core_op`  in  15  decoder AU op
- `host_req`  in  1  host request; level, held until `host_ack`
- `host_slice`  in  2  slice the host op executes for
- `host_op`  in  15  AU op to inject
- `host_ack`  out  1  1-cycle pulse: request consumed (issued or timed out)
- `host_busy`  out  1  request accepted and response not yet delivered
- `host_rsp_vld`  out  1  1-cycle response pulse
- `host_rsp_data`  out  32  captured `au_rc`; 0 if no writeback or on error
- `host_rsp_wb`  out  1  AU wrote back a register for the host op
- `host_rsp_err`  out  1  request timed out; never issued
- `au_op_vld`  out  1  to AU
- `au_op`  out  15  to AU
- `au_rc_vld`  in  1  AU writeback valid
- `au_rc`  in  32  AU writeback data

## Operation
- States: IDLE, WAIT, FLIGHT, RESP.
- IDLE: when `host_req`=1, latch `host_slice`/`host_op`, clear the wait counter, and go to WAIT in the next cycle.
- WAIT: grant condition is `slice`==latched slice and `core_op_vld`=0.
  - On grant: drive `au_op_vld`=1 and `au_op`=latched op, pulse `host_ack`, load the flight counter with 1, go to FLIGHT.
  - Otherwise the wait counter increments (8-bit).
  - If the counter equals `TIMEOUT` with no grant: pulse `host_ack`, go to RESP with err=1.
  - If grant and timeout coincide, the grant wins.
- FLIGHT: the counter decrements. Two cycles after issue (issue cycle t, capture at t+2), capture `au_rc_vld`→wb and `au_rc`→data (data forced to 0 when wb=0). Then go to RESP.
- RESP: pulse `host_rsp_vld` for one cycle with data/wb/err. Return to IDLE.
- `au_op_vld` = `core_op_vld` | grant. `au_op` = `core_op` unless grant. Core ops are never delayed, dropped or modified.
- `host_busy` = 1 in WAIT, FLIGHT and RESP.
- `host_req` is ignored outside IDLE. A new request is accepted in the cycle after the RESP pulse at the earliest.
- A core op issued at t+1 or later writes back at t+3 or later, so the t+2 capture window belongs only to the host op.
- Asynchronous reset mid-operation: state→IDLE, counters cleared, all outputs 0, in-flight capture discarded. An AU op already issued still completes inside the AU and is not reported.

## Timing
- Reset values: `host_ack`, `host_busy`, `host_rsp_vld`, `host_rsp_wb`, `host_rsp_err`, `au_op_vld` = 0; `host_rsp_data` = 0; `au_op` follows `core_op`.
- Request latched at cycle r. The earliest grant is at r+1.
- Granted path: grant at t, capture at t+2, `host_rsp_vld` at t+3. `host_rsp_*` are registered and hold until the next response.
- Timeout path: `host_ack` at r+1+`TIMEOUT`, `host_rsp_vld` one cycle later.
- `au_op_vld`/`au_op` are combinational from `core_op_*`, `slice` and state: zero added latency on the core path.

## Structure
- Shared package `tawas_pkg`:
  - AU op width (15)
  - slice width (2)
  - AU writeback latency constant (2), used to load the flight counter
  - state enum
- No sub-module; one FSM plus two counters.

## Test plan
- Idle core, `slice` free-running, host ADD-imm on slice 2 targeting r1 with r1=5, imm 3 → grant when `slice`=2, `au_op_vld`=1 with the host op, `host_rsp_vld` 3 cycles later with data=8, wb=1, err=0.
- Host compare op (tworeg cmd 0xB, no writeback) → `host_rsp_wb`=0, data=0, `host_rsp_vld` still pulses.
- `core_op_vld`=1 on every slice-1 slot, host targets slice 1, `TIMEOUT`=8 → no injection, `host_ack` at r+9, `host_rsp_err`=1, core ops unchanged throughout.
- Core op on slice 3 in the same cycle the host op targeting slice 3 becomes eligible → core op passes; host op granted at the next free slice-3 slot.
- Grant and timeout coincide (counter=`TIMEOUT` with slot free) → grant wins, err=0.
- Assert `rst` during FLIGHT → all outputs 0 immediately, no `host_rsp_vld`; a fresh request afterwards completes normally.
